frame_header_parser: RTL and testbench
======================================

FRAME_HEADER_PARSER -- requirements
Module: frame_header_parser

Interface
REQ-001 Parameter MAX_WIDTH, default 1024, largest legal image width in pixels.
REQ-002 Parameter MAX_HEIGHT, default 1024, largest legal image height in pixels.
REQ-003 Parameter TIMEOUT_CYCLES, default 65536, idle clk cycles allowed mid-header or mid-frame before abort.
REQ-004 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 data_in  input  8  byte from uart_rx.
REQ-007 valid_in  input  1  one-cycle strobe qualifying data_in; no backpressure is possible upstream.
REQ-008 pix_data  output  8  pixel byte to sobel_applier.
REQ-009 pix_valid  output  1  pix_data qualifier, held until accepted.
REQ-010 pix_ready  input  1  downstream accept; a transfer occurs when pix_valid and pix_ready are both high.
REQ-011 row_last  output  1  qualifies the last pixel of a row; valid only with pix_valid.
REQ-012 frame_last  output  1  qualifies the last pixel of the frame; valid only with pix_valid.
REQ-013 img_width, img_height  output  16 each  accepted frame dimensions.
REQ-014 hdr_valid  output  1  one-cycle pulse when a legal header is accepted.
REQ-015 err_hdr, err_timeout  output  1 each  one-cycle error pulses.
REQ-016 err_overrun  output  1  sticky error flag.
REQ-017 busy  output  1  high in any state other than HDR with byte index 0.

Function
REQ-018 The header SHALL be 4 bytes: width little-endian (bytes 0,1), then height little-endian (bytes 2,3); all following bytes are pixels, raster order.
REQ-019 States: HDR (byte index 0..3) and PIX; every valid_in in HDR SHALL store the byte and increment the index.
REQ-020 On the 4th header byte, width==0, height==0, width>MAX_WIDTH or height>MAX_HEIGHT SHALL pulse err_hdr on the next cycle, leave img_width and img_height unchanged and return to HDR index 0.
REQ-021 On a legal 4th header byte, the block SHALL update img_width and img_height, pulse hdr_valid on the next cycle, clear the column and row counters and enter PIX.
REQ-022 In PIX, each valid_in byte SHALL appear on pix_data with pix_valid one cycle later (latency 1).
REQ-023 row_last SHALL be high when column==width-1.
REQ-024 frame_last SHALL be high when, in addition to row_last, row==height-1; after that byte is loaded, the state SHALL return to HDR index 0.
REQ-025 The column counter SHALL wrap to 0 at width-1 and increment the row counter; width=1 and height=1 SHALL give row_last and frame_last on the same beat.
REQ-026 pix_valid SHALL drop on the cycle after acceptance, unless a new byte loads on that same edge.
REQ-027 A byte arriving while pix_valid is high and pix_ready is low SHALL be dropped (counters still advance) and SHALL set err_overrun until reset.
REQ-028 A byte arriving on the same cycle as acceptance SHALL load normally.
REQ-029 The idle counter SHALL reset on every valid_in and count in HDR index>0 and in PIX.
REQ-030 When the idle counter reaches TIMEOUT_CYCLES, the block SHALL pulse err_timeout and go to HDR index 0; a pending pix_valid is still delivered.
REQ-031 Header bytes SHALL never appear on pix_data.

Reset
REQ-032 On rst: state HDR, index 0; counters 0; pix_data 0; pix_valid, row_last, frame_last, hdr_valid, err_hdr, err_timeout, err_overrun, busy 0; img_width and img_height 0.
REQ-033 Reset mid-frame SHALL discard the partial frame; the next byte after release SHALL be treated as header byte 0.

Structure
REQ-034 Package frame_pkg SHALL hold the state enum, HDR_BYTES=4 and the dim_t 16-bit typedef.
REQ-035 The block SHALL be a single module with no sub-module.

Verification
REQ-036 Header 08 00 04 00 + bytes 0..31 -> one hdr_valid, width 8, height 4, 32 pixels 0..31, row_last on 7/15/23/31, frame_last on 31, busy low afterwards.
REQ-037 Header 00 00 08 00 -> err_hdr pulse, no hdr_valid, no pixels; following header 0C 00 08 00 + 96 bytes accepted fully.
REQ-038 Header 0C 00 08 00 + 40 bytes, then idle TIMEOUT_CYCLES -> err_timeout once, exactly 40 pixels out, next header parses from byte 0.
REQ-039 pix_ready low, two pixel bytes -> first held on pix_data, second dropped, err_overrun high until rst.
REQ-040 rst pulsed after 10 pixels of 8x8 frame -> all outputs 0; new header 02 00 02 00 + 4 bytes -> 4 pixels, frame_last on 4th.
REQ-041 Back-to-back headers 01 00 01 00 + 1 byte, twice -> two hdr_valid pulses, each pixel with row_last and frame_last both high.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared types and constants for the frame header parser.
package frame_pkg;

  localparam int HDR_BYTES = 4;
  localparam int HDR_IDX_W = $clog2(HDR_BYTES);

  typedef logic [15:0] dim_t;

  typedef enum logic [0:0] {
    ST_HDR = 1'b0,
    ST_PIX = 1'b1
  } state_t;

endpackage

// File: rtl/frame_header_parser.sv
// Parses a 4-byte little-endian width/height header from a byte stream and
// forwards the following pixel bytes with row/frame boundary markers.
module frame_header_parser
  import frame_pkg::*;
#(
  parameter int unsigned MAX_WIDTH      = 1024,
  parameter int unsigned MAX_HEIGHT     = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic [7:0] pix_data,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       row_last,
  output logic       frame_last,
  output dim_t       img_width,
  output dim_t       img_height,
  output logic       hdr_valid,
  output logic       err_hdr,
  output logic       err_timeout,
  output logic       err_overrun,
  output logic       busy
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                 state_reg;
  logic [HDR_IDX_W-1:0]   hdr_idx_reg;
  logic [7:0]             hdr_b0_reg;
  logic [7:0]             hdr_b1_reg;
  logic [7:0]             hdr_b2_reg;
  dim_t                   col_reg;
  dim_t                   row_reg;
  logic [IDLE_W-1:0]      idle_reg;

  dim_t width_cand;
  dim_t height_cand;
  logic hdr_last;
  logic hdr_bad;
  logic col_last;
  logic row_end;
  logic idle_active;
  logic timeout_hit;
  logic out_stalled;

  // The last header byte is still on data_in, so height is assembled from it directly.
  assign width_cand  = {hdr_b1_reg, hdr_b0_reg};
  assign height_cand = {data_in, hdr_b2_reg};
  assign hdr_last    = (hdr_idx_reg == HDR_IDX_W'(HDR_BYTES - 1));
  assign hdr_bad     = (width_cand == '0) || (height_cand == '0) ||
                       (32'(width_cand) > MAX_WIDTH) || (32'(height_cand) > MAX_HEIGHT);

  assign col_last    = (col_reg == img_width - dim_t'(1));
  assign row_end     = (row_reg == img_height - dim_t'(1));

  assign idle_active = (state_reg == ST_PIX) || (hdr_idx_reg != '0);
  assign timeout_hit = idle_active && !valid_in &&
                       (idle_reg == IDLE_W'(TIMEOUT_CYCLES - 1));
  assign out_stalled = pix_valid && !pix_ready;

  assign busy = (state_reg != ST_HDR) || (hdr_idx_reg != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_reg <= '0;
    end else if (valid_in || !idle_active || timeout_hit) begin
      idle_reg <= '0;
    end else begin
      idle_reg <= idle_reg + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_HDR;
      hdr_idx_reg <= '0;
      hdr_b0_reg  <= '0;
      hdr_b1_reg  <= '0;
      hdr_b2_reg  <= '0;
      col_reg     <= '0;
      row_reg     <= '0;
      img_width   <= '0;
      img_height  <= '0;
      hdr_valid   <= 1'b0;
      err_hdr     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      pix_data    <= '0;
      pix_valid   <= 1'b0;
      row_last    <= 1'b0;
      frame_last  <= 1'b0;
    end else begin
      hdr_valid   <= 1'b0;
      err_hdr     <= 1'b0;
      err_timeout <= 1'b0;

      // Completed handshake; a byte loading on this same edge overrides below.
      if (pix_valid && pix_ready) begin
        pix_valid  <= 1'b0;
        row_last   <= 1'b0;
        frame_last <= 1'b0;
      end

      if (timeout_hit) begin
        err_timeout <= 1'b1;
        state_reg   <= ST_HDR;
        hdr_idx_reg <= '0;
      end else if (valid_in) begin
        unique case (state_reg)
          ST_HDR: begin
            unique case (hdr_idx_reg)
              HDR_IDX_W'(0): hdr_b0_reg <= data_in;
              HDR_IDX_W'(1): hdr_b1_reg <= data_in;
              HDR_IDX_W'(2): hdr_b2_reg <= data_in;
              default: begin
                if (hdr_bad) begin
                  err_hdr <= 1'b1;
                end else begin
                  img_width  <= width_cand;
                  img_height <= height_cand;
                  hdr_valid  <= 1'b1;
                  col_reg    <= '0;
                  row_reg    <= '0;
                  state_reg  <= ST_PIX;
                end
              end
            endcase
            hdr_idx_reg <= hdr_last ? '0 : hdr_idx_reg + HDR_IDX_W'(1);
          end

          ST_PIX: begin
            // A stalled output slot cannot absorb the byte; it is lost but the raster position still moves.
            if (out_stalled) begin
              err_overrun <= 1'b1;
            end else begin
              pix_data   <= data_in;
              pix_valid  <= 1'b1;
              row_last   <= col_last;
              frame_last <= col_last && row_end;
            end

            if (col_last) begin
              col_reg <= '0;
              if (row_end) begin
                row_reg     <= '0;
                state_reg   <= ST_HDR;
                hdr_idx_reg <= '0;
              end else begin
                row_reg <= row_reg + dim_t'(1);
              end
            end else begin
              col_reg <= col_reg + dim_t'(1);
            end
          end

          default: begin
            state_reg   <= ST_HDR;
            hdr_idx_reg <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_header_parser.sv
// Scoreboard bench for frame_header_parser: stimulus queues expected pixels and
// headers, a forked monitor pops and compares whenever the DUT presents them.
module tb_frame_header_parser;

  localparam int TO_CYCLES = 100;

  typedef struct packed {
    logic [7:0] d;
    logic       rl;
    logic       fl;
  } pix_t;

  logic        clk;
  logic        rst;
  logic [7:0]  data_in;
  logic        valid_in;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        row_last;
  logic        frame_last;
  logic [15:0] img_width;
  logic [15:0] img_height;
  logic        hdr_valid;
  logic        err_hdr;
  logic        err_timeout;
  logic        err_overrun;
  logic        busy;

  pix_t        exp_q[$];
  logic [31:0] hdr_q[$];

  int checks;
  int failures;
  int hdr_cnt;
  int err_hdr_cnt;
  int err_to_cnt;

  frame_header_parser #(
    .MAX_WIDTH(1024),
    .MAX_HEIGHT(1024),
    .TIMEOUT_CYCLES(TO_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .valid_in(valid_in),
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .row_last(row_last),
    .frame_last(frame_last),
    .img_width(img_width),
    .img_height(img_height),
    .hdr_valid(hdr_valid),
    .err_hdr(err_hdr),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    valid_in = 1'b1;
    data_in  = b;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] w, input logic [15:0] h);
    send(w[7:0]);
    send(w[15:8]);
    send(h[7:0]);
    send(h[15:8]);
  endtask

  task automatic push_frame(input int w, input int h, input int n, input int base);
    pix_t p;
    for (int i = 0; i < n; i++) begin
      p.d  = 8'(base + i);
      p.rl = ((i % w) == w - 1);
      p.fl = (i == w * h - 1);
      exp_q.push_back(p);
    end
  endtask

  task automatic send_pixels(input int n, input int base);
    for (int i = 0; i < n; i++) send(8'(base + i));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pix_data"}, pix_data, 0);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_row_last"}, row_last, 0);
    chk({tag, "_frame_last"}, frame_last, 0);
    chk({tag, "_hdr_valid"}, hdr_valid, 0);
    chk({tag, "_err_hdr"}, err_hdr, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
    chk({tag, "_err_overrun"}, err_overrun, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_img_width"}, img_width, 0);
    chk({tag, "_img_height"}, img_height, 0);
  endtask

  task automatic monitor();
    pix_t        e;
    logic [31:0] eh;
    forever begin
      @(negedge clk);
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_pixel actual=%0h required=none", pix_data);
        end else begin
          e = exp_q.pop_front();
          chk("pix_data", pix_data, e.d);
          chk("row_last", row_last, e.rl);
          chk("frame_last", frame_last, e.fl);
          $display("pixel data=%02h row_last=%0b frame_last=%0b", pix_data, row_last, frame_last);
        end
      end
      if (hdr_valid) begin
        hdr_cnt++;
        if (hdr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_hdr_valid actual=%0dx%0d required=none", img_width, img_height);
        end else begin
          eh = hdr_q.pop_front();
          chk("img_width", img_width, eh[31:16]);
          chk("img_height", img_height, eh[15:0]);
          $display("header width=%0d height=%0d", img_width, img_height);
        end
      end
      if (err_hdr) err_hdr_cnt++;
      if (err_timeout) err_to_cnt++;
    end
  endtask

  initial begin
    int hc;
    int eh;
    int et;
    pix_t p;
    checks = 0;
    failures = 0;
    hdr_cnt = 0;
    err_hdr_cnt = 0;
    err_to_cnt = 0;
    rst = 1'b1;
    valid_in = 1'b0;
    data_in = 8'h00;
    pix_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    fork
      monitor();
    join_none
    tick();

    // 8x4 frame with ramp data
    hc = hdr_cnt;
    hdr_q.push_back({16'd8, 16'd4});
    push_frame(8, 4, 32, 0);
    send_hdr(16'd8, 16'd4);
    chk("busy_in_frame", busy, 1);
    send_pixels(32, 0);
    drain();
    tick();
    chk("busy_after_frame", busy, 0);
    chk("hdr_count_8x4", hdr_cnt - hc, 1);

    // zero width rejected, dimensions preserved, then a legal 12x8 frame
    hc = hdr_cnt;
    eh = err_hdr_cnt;
    send_hdr(16'd0, 16'd8);
    tick();
    tick();
    chk("err_hdr_zero_width", err_hdr_cnt - eh, 1);
    chk("no_hdr_valid_on_bad", hdr_cnt - hc, 0);
    chk("width_kept", img_width, 8);
    chk("height_kept", img_height, 4);
    chk("busy_after_bad_hdr", busy, 0);
    hdr_q.push_back({16'd12, 16'd8});
    push_frame(12, 8, 96, 100);
    send_hdr(16'd12, 16'd8);
    send_pixels(96, 100);
    drain();

    // partial frame abandoned by idle timeout, next header parses cleanly
    et = err_to_cnt;
    hdr_q.push_back({16'd12, 16'd8});
    push_frame(12, 8, 40, 0);
    send_hdr(16'd12, 16'd8);
    send_pixels(40, 0);
    drain();
    repeat (TO_CYCLES + 10) tick();
    chk("err_timeout_once", err_to_cnt - et, 1);
    chk("busy_after_timeout", busy, 0);
    hdr_q.push_back({16'd2, 16'd2});
    push_frame(2, 2, 4, 200);
    send_hdr(16'd2, 16'd2);
    send_pixels(4, 200);
    drain();

    // overrun: second byte dropped while output is stalled
    hdr_q.push_back({16'd2, 16'd2});
    send_hdr(16'd2, 16'd2);
    pix_ready = 1'b0;
    p = '{d: 8'hA1, rl: 1'b0, fl: 1'b0};
    exp_q.push_back(p);
    send(8'hA1);
    send(8'hA2);
    chk("overrun_flag", err_overrun, 1);
    chk("held_pix_valid", pix_valid, 1);
    tick();
    chk("held_pix_data", pix_data, 8'hA1);
    p = '{d: 8'hA3, rl: 1'b0, fl: 1'b0};
    exp_q.push_back(p);
    p = '{d: 8'hA4, rl: 1'b1, fl: 1'b1};
    exp_q.push_back(p);
    pix_ready = 1'b1;
    send(8'hA3);
    send(8'hA4);
    drain();
    chk("overrun_sticky", err_overrun, 1);

    // reset mid-frame, then a fresh 2x2 frame
    hdr_q.push_back({16'd8, 16'd8});
    push_frame(8, 8, 10, 0);
    send_hdr(16'd8, 16'd8);
    send_pixels(10, 0);
    drain();
    rst = 1'b1;
    #2;
    check_zero("midreset");
    tick();
    rst = 1'b0;
    tick();
    hdr_q.push_back({16'd2, 16'd2});
    push_frame(2, 2, 4, 8'h40);
    send_hdr(16'd2, 16'd2);
    send_pixels(4, 8'h40);
    drain();

    // back-to-back 1x1 frames
    hc = hdr_cnt;
    hdr_q.push_back({16'd1, 16'd1});
    hdr_q.push_back({16'd1, 16'd1});
    p = '{d: 8'h55, rl: 1'b1, fl: 1'b1};
    exp_q.push_back(p);
    p = '{d: 8'h66, rl: 1'b1, fl: 1'b1};
    exp_q.push_back(p);
    send_hdr(16'd1, 16'd1);
    send(8'h55);
    send_hdr(16'd1, 16'd1);
    send(8'h66);
    drain();
    tick();
    chk("hdr_count_1x1", hdr_cnt - hc, 2);
    chk("headers_pending", hdr_q.size(), 0);
    chk("busy_at_end", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
